// File: rtl/tcm_loader.sv
// tcm_loader: byte-stream program loader for the core's ITCM/DTCM load ports.
// Parses CMD/ADDR/LEN/payload/CSUM frames from a valid/ready byte source,
// issues one registered byte write per payload byte, checks an additive
// 8-bit checksum and can pulse the core start input.
//
// state | meaning
// IDLE  | waiting for a command byte
// ADDR0 | expecting address low byte
// ADDR1 | expecting address high byte
// LEN0  | expecting length low byte
// LEN1  | expecting length high byte
// DATA  | receiving payload bytes, one write per accepted byte
// CSUM  | expecting checksum byte
// START | one-cycle start pulse, input stalled
module tcm_loader #(
  parameter int IAW = 12,
  parameter int DAW = 12
) (
  input  logic           clk,
  input  logic           rst_,
  input  logic           in_valid,
  input  logic [7:0]     in_data,
  output logic           in_ready,
  output logic           itcm_en,
  output logic [IAW-1:0] itcm_addr,
  output logic [7:0]     itcm_data,
  output logic           dtcm_en,
  output logic [DAW-1:0] dtcm_addr,
  output logic [7:0]     dtcm_data,
  output logic           start,
  output logic           busy,
  output logic           err
);

  localparam int AW = (IAW > DAW) ? IAW : DAW;

  localparam logic [7:0] CMD_ITCM  = 8'hA1;
  localparam logic [7:0] CMD_DTCM  = 8'hA2;
  localparam logic [7:0] CMD_START = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR0, S_ADDR1, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_START
  } state_t;

  state_t        state, state_nxt;
  logic          armed;
  logic          xfer;
  logic          tgt_dtcm;
  logic [7:0]    addr_lo;
  logic [7:0]    len_lo;
  logic [7:0]    sum;
  logic [AW-1:0] addr;
  logic [15:0]   count;

  // armed keeps in_ready low for the first cycle after reset release
  assign in_ready = armed && (state != S_START);
  assign xfer     = in_valid && in_ready;
  assign busy     = (state != S_IDLE);
  assign start    = (state == S_START);

  // state register
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // next-state decode; only advances on an accepted byte except in START
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (xfer) begin
          if (in_data == CMD_ITCM || in_data == CMD_DTCM) state_nxt = S_ADDR0;
          else if (in_data == CMD_START)                  state_nxt = S_START;
        end
      end
      S_ADDR0: if (xfer) state_nxt = S_ADDR1;
      S_ADDR1: if (xfer) state_nxt = S_LEN0;
      S_LEN0:  if (xfer) state_nxt = S_LEN1;
      S_LEN1: begin
        if (xfer) state_nxt = ({in_data, len_lo} == 16'd0) ? S_CSUM : S_DATA;
      end
      S_DATA:  if (xfer && count == 16'd1) state_nxt = S_CSUM;
      S_CSUM:  if (xfer) state_nxt = S_IDLE;
      S_START: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // frame datapath, registered write ports and sticky error
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      armed     <= 1'b0;
      tgt_dtcm  <= 1'b0;
      addr_lo   <= 8'd0;
      len_lo    <= 8'd0;
      sum       <= 8'd0;
      addr      <= '0;
      count     <= 16'd0;
      err       <= 1'b0;
      itcm_en   <= 1'b0;
      itcm_addr <= '0;
      itcm_data <= 8'd0;
      dtcm_en   <= 1'b0;
      dtcm_addr <= '0;
      dtcm_data <= 8'd0;
    end else begin
      armed   <= 1'b1;
      itcm_en <= 1'b0;
      dtcm_en <= 1'b0;
      if (xfer) begin
        unique case (state)
          S_IDLE: begin
            if (in_data == CMD_ITCM)       tgt_dtcm <= 1'b0;
            else if (in_data == CMD_DTCM)  tgt_dtcm <= 1'b1;
            else if (in_data != CMD_START) err      <= 1'b1;
          end
          S_ADDR0: addr_lo <= in_data;
          // upper address bits beyond the target width are dropped here
          S_ADDR1: addr <= AW'({in_data, addr_lo});
          S_LEN0:  len_lo <= in_data;
          S_LEN1: begin
            count <= {in_data, len_lo};
            sum   <= 8'd0;
          end
          S_DATA: begin
            sum   <= sum + in_data;
            count <= count - 16'd1;
            addr  <= addr + AW'(1);
            if (tgt_dtcm) begin
              dtcm_en   <= 1'b1;
              dtcm_addr <= addr[DAW-1:0];
              dtcm_data <= in_data;
            end else begin
              itcm_en   <= 1'b1;
              itcm_addr <= addr[IAW-1:0];
              itcm_data <= in_data;
            end
          end
          S_CSUM: if (in_data != sum) err <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tcm_loader.sv
// tb_tcm_loader: directed frames; expected writes/start pulses are queued by
// the stimulus and popped by an independent output monitor.
module tb_tcm_loader;

  localparam int IAW = 12;
  localparam int DAW = 12;

  logic           clk = 1'b0;
  logic           rst_ = 1'b1;
  logic           in_valid = 1'b0;
  logic [7:0]     in_data = 8'd0;
  logic           in_ready;
  logic           itcm_en;
  logic [IAW-1:0] itcm_addr;
  logic [7:0]     itcm_data;
  logic           dtcm_en;
  logic [DAW-1:0] dtcm_addr;
  logic [7:0]     dtcm_data;
  logic           start;
  logic           busy;
  logic           err;

  tcm_loader #(.IAW(IAW), .DAW(DAW)) dut (
    .clk(clk), .rst_(rst_), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .itcm_en(itcm_en), .itcm_addr(itcm_addr),
    .itcm_data(itcm_data), .dtcm_en(dtcm_en), .dtcm_addr(dtcm_addr),
    .dtcm_data(dtcm_data), .start(start), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { int kind; int addr; int data; } ev_t;  // kind 0 itcm, 1 dtcm, 2 start
  typedef logic [7:0] bytes_t[$];

  ev_t exp_q[$];
  int  vectors = 0;
  int  miscompares = 0;
  int  run_len = 0;
  int  max_run = 0;

  task automatic check(input string name, input int act, input int exp_v);
    vectors++;
    if (act != exp_v) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
    end
  endtask

  task automatic expect_ev(input int kind, input int addr, input int data);
    ev_t e;
    e.kind = kind; e.addr = addr; e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind, input int addr, input int data);
    ev_t e;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_event: got kind=%0d addr=0x%0h data=0x%0h, expected none", kind, addr, data);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      check("event_addr", addr, e.addr);
      check("event_data", data, e.data);
    end
  endtask

  // monitor: compares every write / start pulse against the queue
  always @(negedge clk) begin
    if (itcm_en || dtcm_en) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
      check("en_exclusive", int'(itcm_en & dtcm_en), 0);
    end else begin
      run_len = 0;
    end
    if (itcm_en) observe(0, int'(itcm_addr), int'(itcm_data));
    if (dtcm_en) observe(1, int'(dtcm_addr), int'(dtcm_data));
    if (start)   observe(2, 0, 0);
  end

  // called at a negedge; returns at the negedge after the byte transfers
  task automatic send(input logic [7:0] b);
    int n;
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("ready_timeout", int'(in_ready), 1);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input bytes_t f);
    foreach (f[i]) send(f[i]);
  endtask

  task automatic apply_reset();
    in_valid = 1'b0;
    rst_ = 1'b1;
    @(negedge clk);
    rst_ = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bytes_t fr;

    // power-on reset values and first-cycle ready suppression
    repeat (2) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_err", int'(err), 0);
    check("rst_itcm_en", int'(itcm_en), 0);
    rst_ = 1'b0;
    #1;
    check("ready_first_cycle", int'(in_ready), 0);
    @(negedge clk);
    check("ready_second_cycle", int'(in_ready), 1);

    // reset mid-DATA after two of four payload bytes
    expect_ev(0, 12'h000, 8'h11);
    expect_ev(0, 12'h001, 8'h22);
    fr = '{8'hA1, 8'h00, 8'h00, 8'h04, 8'h00, 8'h11, 8'h22};
    send_frame(fr);
    #2;
    rst_ = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h33;
    #1;
    check("mid_rst_itcm_en", int'(itcm_en), 0);
    check("mid_rst_itcm_addr", int'(itcm_addr), 0);
    check("mid_rst_itcm_data", int'(itcm_data), 0);
    check("mid_rst_dtcm_en", int'(dtcm_en), 0);
    check("mid_rst_dtcm_addr", int'(dtcm_addr), 0);
    check("mid_rst_in_ready", int'(in_ready), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_start", int'(start), 0);
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    rst_ = 1'b0;
    #1;
    check("rel_ready_first", int'(in_ready), 0);
    @(negedge clk);
    check("rel_ready_second", int'(in_ready), 1);
    check("rel_busy", int'(busy), 0);
    check("rel_queue_empty", exp_q.size(), 0);

    // ITCM burst, back-to-back
    max_run = 0;
    expect_ev(0, 12'h010, 8'h13);
    expect_ev(0, 12'h011, 8'h00);
    expect_ev(0, 12'h012, 8'h00);
    expect_ev(0, 12'h013, 8'h00);
    send(8'hA1);
    check("busy_in_frame", int'(busy), 1);
    fr = '{8'h10, 8'h00, 8'h04, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
    send_frame(fr);
    check("itcm_err", int'(err), 0);
    check("itcm_busy_after", int'(busy), 0);
    check("itcm_burst_run", max_run, 4);

    // DTCM with address wrap
    expect_ev(1, 12'hFFE, 8'hAA);
    expect_ev(1, 12'hFFF, 8'hBB);
    expect_ev(1, 12'h000, 8'hCC);
    fr = '{8'hA2, 8'hFE, 8'h0F, 8'h03, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'h31};
    send_frame(fr);
    check("dtcm_err", int'(err), 0);
    check("dtcm_busy_after", int'(busy), 0);

    // bad checksum, then start still works
    expect_ev(0, 12'h000, 8'h01);
    expect_ev(0, 12'h001, 8'h02);
    fr = '{8'hA1, 8'h00, 8'h00, 8'h02, 8'h00, 8'h01, 8'h02, 8'hFF};
    send_frame(fr);
    check("csum_err", int'(err), 1);
    expect_ev(2, 0, 0);
    send(8'hA5);
    check("start_ready_low", int'(in_ready), 0);
    check("start_busy", int'(busy), 1);
    @(negedge clk);
    check("start_ready_back", int'(in_ready), 1);
    check("start_err_sticky", int'(err), 1);

    // bad command, then zero-length frame
    apply_reset();
    check("clean_err", int'(err), 0);
    send(8'h7E);
    check("badcmd_err", int'(err), 1);
    check("badcmd_idle", int'(busy), 0);
    fr = '{8'hA1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(fr);
    check("len0_err_kept", int'(err), 1);
    check("len0_idle", int'(busy), 0);
    check("len0_no_writes", exp_q.size(), 0);

    // gapped payload, then start drops ready for one cycle
    apply_reset();
    fr = '{8'hA1, 8'h20, 8'h00, 8'h04, 8'h00};
    send_frame(fr);
    max_run = 0;
    for (int i = 1; i <= 4; i++) begin
      expect_ev(0, 12'h020 + i - 1, i);
      send(8'(i));
      @(negedge clk);
    end
    send(8'h0A);
    check("gap_err", int'(err), 0);
    check("gap_run", max_run, 1);
    expect_ev(2, 0, 0);
    send(8'hA5);
    check("gap_start_ready_low", int'(in_ready), 0);
    @(negedge clk);
    check("gap_start_ready_back", int'(in_ready), 1);

    repeat (3) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
